// File: rtl/adder_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl_pkg
// Shared definitions for the nibble-serial adder sequencer.
//   state_t  : controller state encoding (IDLE / RUN / DONE)
//   NIBBLE_W : width of one slice handled by the shared 4-bit adder
// -----------------------------------------------------------------------------
package adder_seq_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : adder_seq_ctrl_pkg

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
// 4-bit ripple-carry adder.
//   a, b  : 4-bit operands
//   cin   : carry-in
//   s     : 4-bit sum
//   cout  : carry-out of bit 3
// -----------------------------------------------------------------------------
module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = w_c[4];

endmodule : adder

// File: rtl/adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl
// Performs WIDTH-bit additions through a single shared 4-bit adder, one nibble
// per clock, least significant nibble first.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   in_a, in_b, in_cin  : operands, sampled at the accepting edge only
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   out_sum, out_cout   : (A + B + cin) mod 2^WIDTH and carry out of bit WIDTH-1
//   busy                : controller not in IDLE
// -----------------------------------------------------------------------------
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    // Operands and result viewed as nibble arrays so the active slice can be
    // selected by comparing against the index rather than by variable shifts.
    state_t                             r_state;
    state_t                             w_state_next;
    logic [IDX_W-1:0]                   r_idx;
    logic                               r_carry;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   r_a;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   r_b;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   r_sum;
    logic                               r_cout;

    logic [NIBBLES-1:0][NIBBLE_W-1:0]   w_sum_next;
    logic [NIBBLE_W-1:0]                w_nib_a;
    logic [NIBBLE_W-1:0]                w_nib_b;
    logic [NIBBLE_W-1:0]                w_nib_s;
    logic                               w_nib_cout;
    logic                               w_last;
    logic                               w_in_ready;
    logic                               w_out_valid;
    logic                               w_busy;

    // ---------------------------------------------------------------------
    // Shared 4-bit adder
    // ---------------------------------------------------------------------
    adder u_adder (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .s    (w_nib_s),
        .cout (w_nib_cout)
    );

    // Nibble select for the adder inputs and nibble insert for the sum.
    always_comb begin
        w_nib_a    = '0;
        w_nib_b    = '0;
        w_sum_next = r_sum;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDX_W'(n)) begin
                w_nib_a       = r_a[n];
                w_nib_b       = r_b[n];
                w_sum_next[n] = w_nib_s;
            end
        end
    end

    assign w_last = (r_idx == LAST_IDX);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: operand capture, nibble index, carry chain and result
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_nib_cout;
                    // Index wraps to 0 after the final nibble so it is
                    // already clean for the next operation.
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_nib_cout;
                    end else begin
                        r_idx  <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

endmodule : adder_seq_ctrl

// File: tb/tb_adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_seq_ctrl
// Directed self-checking bench for adder_seq_ctrl (WIDTH=16 and WIDTH=4).
// -----------------------------------------------------------------------------
module tb_adder_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] in_a      = '0;
    logic [15:0] in_b      = '0;
    logic        in_cin    = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        busy;

    logic        in_valid4  = 1'b0;
    logic        in_ready4;
    logic [3:0]  in_a4      = '0;
    logic [3:0]  in_b4      = '0;
    logic        in_cin4    = 1'b0;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic [3:0]  out_sum4;
    logic        out_cout4;
    logic        busy4;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    adder_seq_ctrl #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_a      (in_a4),
        .in_b      (in_b4),
        .in_cin    (in_cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_sum   (out_sum4),
        .out_cout  (out_cout4),
        .busy      (busy4)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, then wait (bounded) for out_valid.
    // Returns the number of edges from acceptance to out_valid.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            output int unsigned lat);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_cin   = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
        int unsigned lat;
        start_op(a, b, cin, lat);
        check_val({tag, "_latency"}, lat, 4);
        check_val({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
        check_val({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
        tick();
        check_val({tag, "_valid_drop"}, 32'(out_valid), 0);
        check_val({tag, "_in_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        int unsigned lat;
        int unsigned seen_valid;

        // Reset state
        #12;
        check_val("rst_in_ready", 32'(in_ready), 1);
        check_val("rst_out_valid", 32'(out_valid), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_sum", 32'(out_sum), 0);
        check_val("rst_cout", 32'(out_cout), 0);
        check_val("rst_in_ready4", 32'(in_ready4), 1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic op with detailed edge timing
        in_a = 16'h00FF; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("t1_busy", 32'(busy), 1);
        check_val("t1_in_ready", 32'(in_ready), 0);
        tick(); tick(); tick();
        check_val("t1_valid_edge3", 32'(out_valid), 0);
        tick();
        check_val("t1_valid_edge4", 32'(out_valid), 1);
        check_val("t1_sum", 32'(out_sum), 32'h0100);
        check_val("t1_cout", 32'(out_cout), 0);
        tick();
        check_val("t1_valid_one_cycle", 32'(out_valid), 0);
        check_val("t1_in_ready_back", 32'(in_ready), 1);

        run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("t3", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // Backpressure with a competing request during the stall
        out_ready = 1'b0;
        start_op(16'h1234, 16'h1111, 1'b0, lat);
        check_val("bp_latency", lat, 4);
        in_a = 16'h0F0F; in_b = 16'h0101; in_cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_valid_held", 32'(out_valid), 1);
            check_val("bp_sum_held", 32'(out_sum), 32'h2345);
            check_val("bp_cout_held", 32'(out_cout), 0);
            check_val("bp_in_ready", 32'(in_ready), 0);
            check_val("bp_busy", 32'(busy), 1);
        end
        out_ready = 1'b1;
        tick();
        check_val("bp_idle", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_a = '0; in_b = '0;
        check_val("bp_second_busy", 32'(busy), 1);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
        check_val("bp_second_latency", lat, 4);
        check_val("bp_second_sum", 32'(out_sum), 32'h1010);
        check_val("bp_second_cout", 32'(out_cout), 0);
        tick();

        // Asynchronous reset mid-RUN
        in_a = 16'h1111; in_b = 16'h2222; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_in_ready", 32'(in_ready), 1);
        check_val("mid_rst_out_valid", 32'(out_valid), 0);
        check_val("mid_rst_busy", 32'(busy), 0);
        check_val("mid_rst_sum", 32'(out_sum), 0);
        check_val("mid_rst_cout", 32'(out_cout), 0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen_valid++;
        end
        check_val("mid_rst_no_valid", seen_valid, 0);
        run_op("post_rst", 16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0);

        // WIDTH=4 instance: single RUN cycle
        in_a4 = 4'hA; in_b4 = 4'hC; in_cin4 = 1'b0; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        check_val("w4_busy", 32'(busy4), 1);
        tick();
        check_val("w4_valid_edge1", 32'(out_valid4), 1);
        check_val("w4_sum", 32'(out_sum4), 32'h6);
        check_val("w4_cout", 32'(out_cout4), 1);
        tick();
        check_val("w4_in_ready", 32'(in_ready4), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_adder_seq_ctrl
